// File: rtl/tlcf_pkg.sv
// Shared encodings for the traffic-light phase counter controller:
// FSM states, phase direction values and mode bit positions.
package tlcf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } tlcf_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam int MODE_SEL_BIT = 0;
  localparam int MODE_ACL_BIT = 1;

endpackage

// File: rtl/tlcf_phase_len_table.sv
// Per-phase duration registers: synchronous write, combinational read by
// phase index, every entry returns to DEF_LEN on reset.
module tlcf_phase_len_table #(
  parameter int              CNT_W      = 8,
  parameter int              NUM_PHASES = 4,
  parameter int              PH_W       = 2,
  parameter logic [CNT_W-1:0] DEF_LEN   = 8'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [PH_W-1:0]  i_wr_phase,
  input  logic [CNT_W-1:0] i_wr_len,
  input  logic [PH_W-1:0]  i_rd_phase,
  output logic [CNT_W-1:0] o_rd_len
);

  logic [CNT_W-1:0] r_len [NUM_PHASES];

  // Indices at or above NUM_PHASES match no entry, so such writes drop out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHASES; i++) r_len[i] <= DEF_LEN;
    end else if (i_we) begin
      for (int i = 0; i < NUM_PHASES; i++)
        if (i_wr_phase == PH_W'(i)) r_len[i] <= i_wr_len;
    end
  end

  always_comb begin
    o_rd_len = r_len[0];
    for (int i = 1; i < NUM_PHASES; i++)
      if (i_rd_phase == PH_W'(i)) o_rd_len = r_len[i];
  end

endmodule

// File: rtl/tlcf_phase_counter_ctrl.sv
// Traffic-light phase sequencer: owns the phase index and the per-phase
// countdown, with optional accelerated (shifted) durations.
//
// state   | meaning
// IDLE    | after reset, waiting for counter_control
// LOAD    | one cycle: load effective duration, latch acl for the phase
// RUN     | counting down while counter_control is high
// HOLD    | counter frozen until counter_control returns high
module tlcf_phase_counter_ctrl
  import tlcf_pkg::*;
#(
  parameter int               CNT_W      = 8,
  parameter int               NUM_PHASES = 4,
  parameter int               PH_W       = 2,
  parameter int               ACL_SHIFT  = 2,
  parameter logic [CNT_W-1:0] DEF_LEN    = 8'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_counter_control,
  input  logic             i_select,
  input  logic             i_acl_select,
  input  logic             i_cfg_we,
  input  logic [PH_W-1:0]  i_cfg_phase,
  input  logic [CNT_W-1:0] i_cfg_len,
  output logic [PH_W-1:0]  o_phase,
  output logic [CNT_W-1:0] o_count,
  output logic             o_phase_done,
  output logic [1:0]       o_mode,
  output logic             o_busy
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  tlcf_state_t      r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_acl_q;
  logic             r_sel_q;

  logic [CNT_W-1:0] w_len_rd;
  logic [CNT_W-1:0] w_len_sh;
  logic [CNT_W-1:0] w_eff;
  logic [PH_W-1:0]  w_ph_next;
  logic             w_busy;

  tlcf_phase_len_table #(
    .CNT_W      (CNT_W),
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W),
    .DEF_LEN    (DEF_LEN)
  ) u_len_table (
    .clk        (clk),
    .reset      (reset),
    .i_we       (i_cfg_we),
    .i_wr_phase (i_cfg_phase),
    .i_wr_len   (i_cfg_len),
    .i_rd_phase (r_phase),
    .o_rd_len   (w_len_rd)
  );

  // A shifted duration of zero would expire instantly; clamp it to one cycle.
  assign w_len_sh = i_acl_select ? (w_len_rd >> ACL_SHIFT) : w_len_rd;
  assign w_eff    = (w_len_sh == '0) ? CNT_W'(1) : w_len_sh;

  always_comb begin
    w_ph_next = r_phase + 1'b1;
    if (i_select == DIR_REV)
      w_ph_next = (r_phase == '0) ? LAST_PH : r_phase - 1'b1;
    else if (r_phase == LAST_PH)
      w_ph_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_acl_q <= 1'b0;
      r_sel_q <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_sel_q <= i_select;
      case (r_state)
        ST_IDLE: if (i_counter_control) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_count <= w_eff;
          r_acl_q <= i_acl_select;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_counter_control) begin
            r_state <= ST_HOLD;
          end else if (r_count > CNT_W'(1)) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_count <= '0;
            r_done  <= 1'b1;
            r_phase <= w_ph_next;
            r_state <= ST_LOAD;
          end
        end
        ST_HOLD: if (i_counter_control) r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_busy                = (r_state != ST_IDLE);
  assign o_busy                = w_busy;
  assign o_phase               = r_phase;
  assign o_count               = r_count;
  assign o_phase_done          = r_done;
  assign o_mode[MODE_ACL_BIT]  = r_acl_q & w_busy;
  assign o_mode[MODE_SEL_BIT]  = r_sel_q;

endmodule

// File: tb/tb_tlcf_phase_counter_ctrl.sv
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a behavioural phase/timer model.
module tb_tlcf_phase_counter_ctrl;

  localparam int CNT_W      = 8;
  localparam int NUM_PHASES = 4;
  localparam int PH_W       = 2;
  localparam int ACL_SHIFT  = 2;
  localparam int DEF_LEN    = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             cc, sel, acl, we;
  logic [PH_W-1:0]  cfg_ph;
  logic [CNT_W-1:0] cfg_len;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] count;
  logic             phase_done;
  logic [1:0]       mode;
  logic             busy;

  always #5 clk = ~clk;

  tlcf_phase_counter_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .i_counter_control (cc),
    .i_select          (sel),
    .i_acl_select      (acl),
    .i_cfg_we          (we),
    .i_cfg_phase       (cfg_ph),
    .i_cfg_len         (cfg_len),
    .o_phase           (phase),
    .o_count           (count),
    .o_phase_done      (phase_done),
    .o_mode            (mode),
    .o_busy            (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: durations table plus "where are we in the current phase".
  int m_len [NUM_PHASES];
  int m_phase, m_count;
  bit m_busy, m_load_next, m_frozen, m_done, m_acl, m_sel;

  function automatic int eff_len(int len, bit fast);
    int e;
    e = fast ? len / (1 << ACL_SHIFT) : len;
    return (e == 0) ? 1 : e;
  endfunction

  task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_load_next = 0; m_frozen = 0; m_done = 0;
      m_acl = 0; m_sel = 0; m_phase = 0; m_count = 0;
      for (int i = 0; i < NUM_PHASES; i++) m_len[i] = DEF_LEN;
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (cc) begin m_busy = 1; m_load_next = 1; end
    end else if (m_load_next) begin
      m_count = eff_len(m_len[m_phase], acl);
      m_acl = acl;
      m_load_next = 0;
    end else if (m_frozen) begin
      if (cc) m_frozen = 0;
    end else if (!cc) begin
      m_frozen = 1;
    end else if (m_count > 1) begin
      m_count--;
    end else begin
      m_count = 0;
      m_done = 1;
      m_phase = (m_phase + (sel ? NUM_PHASES - 1 : 1)) % NUM_PHASES;
      m_load_next = 1;
    end
    m_sel = sel;
    if (we && cfg_ph < NUM_PHASES) m_len[cfg_ph] = cfg_len;
  endtask

  task automatic step(bit r, bit c, bit s, bit a, bit w, int ph, int ln);
    @(negedge clk);
    reset = r; cc = c; sel = s; acl = a; we = w;
    cfg_ph = PH_W'(ph); cfg_len = CNT_W'(ln);
    @(posedge clk);
    model_step();
    #1;
    chk_eq("phase", 32'(phase), 32'(m_phase));
    chk_eq("count", 32'(count), 32'(m_count));
    chk_eq("phase_done", 32'(phase_done), 32'(m_done));
    chk_eq("mode", 32'(mode), 32'({m_acl & m_busy, m_sel}));
    chk_eq("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    bit s_cur, a_cur, r, w;
    int ph;
    reset = 1; cc = 0; sel = 0; acl = 0; we = 0; cfg_ph = '0; cfg_len = '0;

    // reset, then four full default phases and the 3 -> 0 wrap
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    repeat (50) step(0, 1, 0, 0, 0, 0, 0);
    // accelerated durations: 10 >> 2 = 2
    repeat (12) step(0, 1, 0, 1, 0, 0, 0);
    // len 2 under acl shifts to 0 and is clamped to 1
    for (int i = 0; i < NUM_PHASES; i++) step(0, 1, 0, 1, 1, i, 2);
    repeat (10) step(0, 1, 0, 1, 0, 0, 0);
    // restore 10s, then toggle acl mid-RUN
    for (int i = 0; i < NUM_PHASES; i++) step(0, 1, 0, 0, 1, i, 10);
    repeat (14) step(0, 1, 0, 0, 0, 0, 0);
    repeat (3)  step(0, 1, 0, 1, 0, 0, 0);
    repeat (4)  step(0, 1, 0, 0, 0, 0, 0);
    // freeze for 7 cycles and resume
    repeat (7)  step(0, 0, 0, 0, 0, 0, 0);
    repeat (15) step(0, 1, 0, 0, 0, 0, 0);
    // reverse direction, then forward again
    repeat (25) step(0, 1, 1, 0, 0, 0, 0);
    repeat (25) step(0, 1, 0, 0, 0, 0, 0);
    // shorten phase 2 mid-flight and on its LOAD cycle, then run on
    repeat (40) begin
      w = (m_phase == 2);
      step(0, 1, 0, 0, w, 2, 3);
    end
    // mid-phase reset after table edits: defaults must come back
    step(0, 1, 0, 0, 1, 0, 3);
    repeat (5) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    repeat (15) step(0, 1, 0, 0, 0, 0, 0);

    s_cur = 0; a_cur = 0;
    repeat (3000) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) s_cur = ~s_cur;
      if ($urandom_range(0, 9) == 0)  a_cur = ~a_cur;
      w  = ($urandom_range(0, 9) == 0);
      ph = (m_load_next && $urandom_range(0, 1) == 1) ? m_phase
                                                       : int'($urandom_range(0, NUM_PHASES - 1));
      step(r, $urandom_range(0, 9) != 0, s_cur, a_cur, w, ph,
           int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
